vn_serial_unit: RTL and testbench
=================================

// Module: vn_serial_unit
// PURPOSE
//  Parametrised variable-node processor for the VFU. Generalises the fixed 5-input VN to run-time degree up to DEG_MAX and generic message width Q.
//  Consumes one sign-magnitude message per cycle: channel LLR first, then deg check-node messages. Stores them and accumulates the APP sum.
//  Then streams out deg extrinsic VN->CN messages, plus the saturated APP value and the hard decision, under valid/ready handshakes.
// PARAMETERS
//  Q        3  message width, sign-magnitude: bit Q-1 = sign, [Q-2:0] = magnitude
//  DEG_MAX  5  max CN messages per job; sizes the message buffer and index
//  IDX_W    $clog2(DEG_MAX)  width of out_idx (derived, min 1)
//  ACC_W    Q+$clog2(DEG_MAX+2)  two's-complement accumulator width (derived)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        unit accepts a beat this cycle
//  in_data    in   Q        SM message: beat 0 = channel LLR, beats 1..deg = CN messages
//  in_deg     in   IDX_W+1  job degree, sampled only on beat 0
//  out_valid  out  1        extrinsic message valid
//  out_ready  in   1        downstream accepts extrinsic message
//  out_msg    out  Q        SM extrinsic message = sat(APP - cn[out_idx])
//  out_idx    out  IDX_W    CN slot of out_msg, 0..deg-1
//  out_last   out  1        out_msg is the job's final message
//  app_sum    out  Q        SM saturated APP (LLR + all CN), held until next job's beat 0
//  hard_bit   out  1        APP sign bit; 1 when APP < 0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0 during reset, 1 on the first cycle after; all other outputs 0; accumulator, buffer and counters cleared.
//  Conversion: SM->TC. Negative zero (sign=1, mag=0) is normalised to 0. Negative values are -mag.
//  Conversion: TC->SM saturates symmetrically to +/-(2^(Q-1)-1). Zero is always output as +0 (all bits 0).
//  Arithmetic: ACC_W-bit signed, no internal wrap. Each buffer entry is Q-bit TC.
//  FSM IDLE: in_ready=1. On beat 0 accepted, sample deg = min(in_deg, DEG_MAX), set acc = LLR, cnt = 0.
//      If deg == 0, go to CALC. Otherwise go to LOAD.
//  FSM LOAD: in_ready=1. Each accepted beat does buf[cnt] <= msg, acc += msg, cnt++.
//      After beat cnt == deg-1, go to CALC.
//  FSM CALC: in_ready=0, one cycle. Register app_sum and hard_bit. Register the first out_msg (idx 0).
//      If deg == 0, return to IDLE with no outputs emitted. Otherwise go to EMIT with out_valid=1.
//  FSM EMIT: in_ready=0. out_msg, out_idx and out_last are flops and stay stable while out_valid & !out_ready.
//      On handshake, idx++ and the next message is registered with no bubble.
//      On the handshake where out_last=1, out_valid drops and state goes to IDLE. in_ready=1 the next cycle.
//  Latency: last input beat accepted at cycle T -> app_sum valid and out_valid=1 at T+2. Sustained rate is 1 message/cycle.
//  Input gaps (in_valid low mid-job) stall LOAD indefinitely. Jobs never overlap.
//  A reset at any point aborts the job immediately. No partial output appears after reset.
//  in_deg outside 0..DEG_MAX is clamped to DEG_MAX. Inputs on non-beat-0 cycles ignore in_deg.
// STRUCTURE
//  vfu_pkg holds the following shared items:
//   - Q default and the vn_state_t enum {IDLE, LOAD, CALC, EMIT}
//   - functions sm2tc(Q) and tc2sm_sat(ACC_W->Q), shared with the CN-side units
//  One sub-module, vn_msg_sat: combinational ACC_W-bit TC -> Q-bit SM with saturation.
//  It is instantiated twice, once for out_msg-next and once for app_sum.
//  The buffer is a DEG_MAX x Q register array, not RAM, so all entries are readable the same cycle.
// TESTING (Q=3, DEG_MAX=5)
//  1. deg=5. Inputs: LLR 010, CN 001,001,101,011,110.
//     Expect app_sum=011, hard_bit=0.
//     Expect out_msg idx0..4 = 011,011,011,001,011. out_last on idx4.
//  2. deg=5. Every input 100 (negative zero).
//     Expect every out_msg=000, app_sum=000, hard_bit=0.
//  3. deg=5. Every input 111.
//     Expect every out_msg=111, app_sum=111, hard_bit=1 (negative saturation).
//  4. deg=2. Inputs: LLR 001, CN 010,111.
//     Expect out_msg 110 then 011, app_sum=000. Then deg=0 with LLR 101: expect app_sum=101, hard_bit=1, no out_valid.
//  5. Hold out_ready=0 for 4 cycles at idx2 of test 1.
//     Expect out_msg/out_idx stable, in_ready=0. Then in_valid gaps mid-LOAD: expect results identical to test 1.
//  6. Assert rst_n low during EMIT idx1.
//     Expect all outputs 0 immediately. in_ready=1 after release. A fresh test-1 job then matches test 1 exactly.

Source files
------------

// File: rtl/vfu_pkg.sv
// Shared VFU types and sign-magnitude / two's-complement helpers.
// Used by the VN serial unit and the CN-side units.
package vfu_pkg;

  localparam int VN_Q       = 3;
  localparam int VN_DEG_MAX = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    EMIT
  } vn_state_t;

  // q-bit SM in the low bits of sm; negative zero folds to 0
  function automatic logic signed [31:0] sm2tc(
    input logic [31:0] sm,
    input int          q
  );
    logic [31:0] mag;
    mag = sm & ((32'd1 << (q - 1)) - 32'd1);
    if (sm[q-1])
      return -$signed(mag);
    return $signed(mag);
  endfunction

  // symmetric saturation to +/-(2^(q-1)-1), zero is always +0
  function automatic logic [31:0] tc2sm_sat(
    input logic signed [31:0] v,
    input int                 q
  );
    logic signed [31:0] lim;
    logic [31:0]        sgn;
    lim = $signed((32'd1 << (q - 1)) - 32'd1);
    sgn = 32'd1 << (q - 1);
    if (v > lim)
      return $unsigned(lim);
    if (v < -lim)
      return sgn | $unsigned(lim);
    if (v < 0)
      return sgn | $unsigned(-v);
    return $unsigned(v);
  endfunction

endpackage

// File: rtl/vn_serial_unit_if.sv
// Input beat and extrinsic output handshakes of the VN serial unit.
// master drives beats and out_ready; slave is the unit.
interface vn_serial_unit_if
  import vfu_pkg::*;
#(
  parameter int Q       = VN_Q,
  parameter int DEG_MAX = VN_DEG_MAX
);

  localparam int IDX_W = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [Q-1:0]     in_data;
  logic [IDX_W:0]   in_deg;
  logic             out_valid;
  logic             out_ready;
  logic [Q-1:0]     out_msg;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [Q-1:0]     app_sum;
  logic             hard_bit;

  modport master (
    output in_valid, in_data, in_deg, out_ready,
    input  in_ready, out_valid, out_msg, out_idx,
    input  out_last, app_sum, hard_bit
  );

  modport slave (
    input  in_valid, in_data, in_deg, out_ready,
    output in_ready, out_valid, out_msg, out_idx,
    output out_last, app_sum, hard_bit
  );

endinterface

// File: rtl/vn_msg_sat.sv
// Combinational ACC_W-bit two's-complement to Q-bit SM,
// saturating symmetrically.
module vn_msg_sat
  import vfu_pkg::*;
#(
  parameter int Q     = VN_Q,
  parameter int ACC_W = VN_Q + 3
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [Q-1:0]     sm
);

  logic [31-Q:0] pad_unused;

  assign {pad_unused, sm} = tc2sm_sat(32'(acc), Q);

endmodule

// File: rtl/vn_serial_unit.sv
// Serial variable-node processor: loads LLR + deg CN messages,
// then streams deg extrinsic messages plus saturated APP.
module vn_serial_unit
  import vfu_pkg::*;
#(
  parameter  int Q       = VN_Q,
  parameter  int DEG_MAX = VN_DEG_MAX,
  localparam int IDX_W   = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1,
  localparam int ACC_W   = Q + $clog2(DEG_MAX + 2)
) (
  input logic             clk,
  input logic             rst_n,
  vn_serial_unit_if.slave bus
);

  vn_state_t state, state_nxt;

  logic                    live;
  logic [IDX_W:0]          deg;
  logic [IDX_W:0]          deg_in;
  logic [IDX_W-1:0]        cnt;
  logic [IDX_W-1:0]        sel;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext_acc;
  logic signed [Q-1:0]     cn_buf [DEG_MAX];
  logic signed [Q-1:0]     cn_sel;
  logic signed [Q-1:0]     in_tc;
  logic [31-Q:0]           tc_unused;
  logic [Q-1:0]            nxt_msg;
  logic [Q-1:0]            app_sm;
  logic                    nxt_last;
  logic                    last_load;
  logic                    in_fire;
  logic                    out_fire;

  assign {tc_unused, in_tc} = sm2tc(32'(bus.in_data), Q);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  assign deg_in = (bus.in_deg > (IDX_W+1)'(DEG_MAX))
                ? (IDX_W+1)'(DEG_MAX) : bus.in_deg;

  assign last_load = ({1'b0, cnt} == deg - (IDX_W+1)'(1));

  // slot of the message being prepared: 0 in CALC, else the next one
  assign sel = (state == CALC) ? '0 : bus.out_idx + IDX_W'(1);

  assign nxt_last = ({1'b0, sel} == deg - (IDX_W+1)'(1));

  // live keeps in_ready low while reset is held
  assign bus.in_ready = live & ((state == IDLE) | (state == LOAD));

  always_comb begin
    cn_sel = '0;
    for (int i = 0; i < DEG_MAX; i++)
      if (sel == IDX_W'(i))
        cn_sel = cn_buf[i];
  end

  assign ext_acc = acc - ACC_W'(cn_sel);

  vn_msg_sat #(.Q(Q), .ACC_W(ACC_W)) u_ext_sat (
    .acc (ext_acc),
    .sm  (nxt_msg)
  );

  vn_msg_sat #(.Q(Q), .ACC_W(ACC_W)) u_app_sat (
    .acc (acc),
    .sm  (app_sm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (in_fire)
          state_nxt = (deg_in == '0) ? CALC : LOAD;
      LOAD:
        if (in_fire && last_load)
          state_nxt = CALC;
      CALC:
        state_nxt = (deg == '0) ? IDLE : EMIT;
      EMIT:
        if (out_fire && bus.out_last)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live          <= 1'b0;
      deg           <= '0;
      cnt           <= '0;
      acc           <= '0;
      for (int i = 0; i < DEG_MAX; i++)
        cn_buf[i]   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_msg   <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      bus.app_sum   <= '0;
      bus.hard_bit  <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (in_fire) begin
            deg <= deg_in;
            acc <= ACC_W'(in_tc);
            cnt <= '0;
          end
        end
        LOAD: begin
          if (in_fire) begin
            cn_buf[cnt] <= in_tc;
            acc         <= acc + ACC_W'(in_tc);
            cnt         <= cnt + IDX_W'(1);
          end
        end
        CALC: begin
          bus.app_sum  <= app_sm;
          bus.hard_bit <= acc[ACC_W-1];
          if (deg != '0) begin
            bus.out_valid <= 1'b1;
            bus.out_msg   <= nxt_msg;
            bus.out_idx   <= '0;
            bus.out_last  <= nxt_last;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (bus.out_last) begin
              bus.out_valid <= 1'b0;
            end else begin
              bus.out_idx  <= sel;
              bus.out_msg  <= nxt_msg;
              bus.out_last <= nxt_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vn_serial_unit.sv
// Directed bench for vn_serial_unit (Q=3, DEG_MAX=5).
// Inputs driven and outputs sampled on the falling edge.
module tb_vn_serial_unit;

  typedef logic [2:0] m3_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vn_serial_unit_if #(.Q(3), .DEG_MAX(5)) vif ();

  vn_serial_unit #(.Q(3), .DEG_MAX(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  task automatic chk3(input string tag, input m3_t obs, input m3_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] deg, input m3_t v[6],
                      input int n, input bit gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (gap && i >= 2) begin
        vif.in_valid = 1'b0;
        vif.in_data  = 3'b011;
        vif.in_deg   = 4'd1;
        @(negedge clk);
      end
      vif.in_valid = 1'b1;
      vif.in_data  = v[i];
      vif.in_deg   = (i == 0) ? deg : 4'd1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        ok = vif.in_ready;
        @(negedge clk);
      end
      chk1("beat_accept", ok, 1'b1);
    end
    vif.in_valid = 1'b0;
  endtask

  task automatic expect_out(input m3_t m[5], input int n,
                            input m3_t app, input logic hb,
                            input int stall_at, input int stall_len);
    chk1("calc_out_valid", vif.out_valid, 1'b0);
    chk1("calc_in_ready", vif.in_ready, 1'b0);
    @(negedge clk);
    chk3("app_sum", vif.app_sum, app);
    chk1("hard_bit", vif.hard_bit, hb);
    for (int i = 0; i < n; i++) begin
      chk1("out_valid", vif.out_valid, 1'b1);
      chk3("out_msg", vif.out_msg, m[i]);
      chk3("out_idx", vif.out_idx, 3'(i));
      chk1("out_last", vif.out_last, i == n - 1);
      if (i == stall_at) begin
        vif.out_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          chk1("stall_valid", vif.out_valid, 1'b1);
          chk3("stall_msg", vif.out_msg, m[i]);
          chk3("stall_idx", vif.out_idx, 3'(i));
          chk1("stall_in_ready", vif.in_ready, 1'b0);
        end
        vif.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk1("done_out_valid", vif.out_valid, 1'b0);
    chk1("done_in_ready", vif.in_ready, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_in_ready"}, vif.in_ready, 1'b0);
    chk1({tag, "_out_valid"}, vif.out_valid, 1'b0);
    chk3({tag, "_out_msg"}, vif.out_msg, 3'b000);
    chk3({tag, "_out_idx"}, vif.out_idx, 3'b000);
    chk1({tag, "_out_last"}, vif.out_last, 1'b0);
    chk3({tag, "_app_sum"}, vif.app_sum, 3'b000);
    chk1({tag, "_hard_bit"}, vif.hard_bit, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "watchdog");
  end

  initial begin
    m3_t t1_in [6];
    m3_t t1_out[5];
    t1_in  = '{3'b010, 3'b001, 3'b001, 3'b101, 3'b011, 3'b110};
    t1_out = '{3'b011, 3'b011, 3'b011, 3'b001, 3'b011};

    vif.in_valid  = 1'b0;
    vif.in_data   = 3'b000;
    vif.in_deg    = 4'd0;
    vif.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_reset_in_ready", vif.in_ready, 1'b1);

    // 1: mixed signs, APP saturates at +3
    send(4'd5, t1_in, 6, 1'b0);
    expect_out(t1_out, 5, 3'b011, 1'b0, -1, 0);

    // 2: negative zero everywhere; in_deg 9 clamps to 5
    send(4'd9, '{6{3'b100}}, 6, 1'b0);
    expect_out('{5{3'b000}}, 5, 3'b000, 1'b0, -1, 0);

    // 3: negative saturation
    send(4'd5, '{6{3'b111}}, 6, 1'b0);
    expect_out('{5{3'b111}}, 5, 3'b111, 1'b1, -1, 0);

    // 4: deg 2, then deg 0
    send(4'd2, '{3'b001, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000},
         3, 1'b0);
    expect_out('{3'b110, 3'b011, 3'b000, 3'b000, 3'b000}, 2,
               3'b000, 1'b0, -1, 0);
    send(4'd0, '{3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000},
         1, 1'b0);
    expect_out('{5{3'b000}}, 0, 3'b101, 1'b1, -1, 0);

    // 5: output stall at idx2, then input gaps mid-load
    send(4'd5, t1_in, 6, 1'b0);
    expect_out(t1_out, 5, 3'b011, 1'b0, 2, 4);
    send(4'd5, t1_in, 6, 1'b1);
    expect_out(t1_out, 5, 3'b011, 1'b0, -1, 0);

    // 6: reset during EMIT idx1, then a clean rerun
    send(4'd5, t1_in, 6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk3("pre_reset_idx", vif.out_idx, 3'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    chk_zero("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk1("abort_release_in_ready", vif.in_ready, 1'b1);
    chk1("abort_release_out_valid", vif.out_valid, 1'b0);
    send(4'd5, t1_in, 6, 1'b0);
    expect_out(t1_out, 5, 3'b011, 1'b0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
